// File: rtl/wb_gpio_pkg.sv
// Shared definitions for the Wishbone GPIO port: bus FSM encoding and register map.
package wb_gpio_pkg;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_ACK  = 1'b1
    } wb_state_t;

    localparam logic [2:0] A_OUT = 3'd0;
    localparam logic [2:0] A_DIR = 3'd1;
    localparam logic [2:0] A_IN  = 3'd2;
    localparam logic [2:0] A_SET = 3'd3;
    localparam logic [2:0] A_CLR = 3'd4;
    localparam logic [2:0] A_TGL = 3'd5;
    localparam logic [2:0] A_IEN = 3'd6;
    localparam logic [2:0] A_ISR = 3'd7;

endpackage

// File: rtl/gpio_in_sync.sv
// Two-flop synchroniser for asynchronous pin inputs, with a one-cycle history
// register so callers get a per-bit rising-edge pulse on the synchronised level.
module gpio_in_sync #(
    parameter int WIDTH = 8
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;

    // Shift the pin value through both sync stages and the history register.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            // NOTE: non-blocking so each stage takes its neighbour's pre-edge value;
            // blocking assignments here would collapse the chain into a single flop.
            sync1 <= pins;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign level = sync2;
    assign rise  = sync2 & ~prev;

endmodule

// File: rtl/wb_gpio_port.sv
// Wishbone classic GPIO slave: output and direction registers, synchronised
// input sampling, atomic set/clear/toggle writes and masked rising-edge IRQs.
module wb_gpio_port
    import wb_gpio_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_OUT = '0,
    parameter logic [WIDTH-1:0] RST_DIR = '0
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             STB_I,
    input  logic             WE_I,
    input  logic [2:0]       ADR_I,
    input  logic [WIDTH-1:0] DAT_I,
    output logic [WIDTH-1:0] DAT_O,
    output logic             ACK_O,
    input  logic [WIDTH-1:0] S_I,
    output logic [WIDTH-1:0] S_O,
    output logic [WIDTH-1:0] S_OE,
    output logic             INT_O
);

    wb_state_t        state;
    wb_state_t        state_next;
    logic             access;
    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] dir_r;
    logic [WIDTH-1:0] ien_r;
    logic [WIDTH-1:0] isr_r;
    logic [WIDTH-1:0] dat_r;
    logic             int_r;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] in_level;
    logic [WIDTH-1:0] in_rise;

    gpio_in_sync #(.WIDTH(WIDTH)) u_in_sync (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .pins  (S_I),
        .level (in_level),
        .rise  (in_rise)
    );

    // Bus FSM state register.
    always_ff @(posedge CLK_I) begin
        if (RST_I) state <= W_IDLE;
        else       state <= state_next;
    end

    // Next state: a strobe seen in idle is acknowledged for exactly one cycle.
    always_comb begin
        // NOTE: default assignment first so every path drives state_next and no latch is inferred.
        state_next = state;
        case (state)
            W_IDLE:  if (STB_I) state_next = W_ACK;
            W_ACK:   state_next = W_IDLE;
            default: state_next = W_IDLE;
        endcase
    end

    // FSM outputs: ACK_O is a decode of the registered state.
    always_comb begin
        ACK_O = (state == W_ACK);
    end

    // The access takes effect on the edge leaving W_IDLE.
    assign access = (state == W_IDLE) && STB_I;
    assign w1c    = (access && WE_I && (ADR_I == A_ISR)) ? DAT_I : '0;

    // Read mux; write-only strobe registers read back as zero.
    always_comb begin
        rd_data = '0;
        case (ADR_I)
            A_OUT:   rd_data = out_r;
            A_DIR:   rd_data = dir_r;
            A_IN:    rd_data = in_level;
            A_IEN:   rd_data = ien_r;
            A_ISR:   rd_data = isr_r;
            default: rd_data = '0;
        endcase
    end

    // Writable control registers, including the atomic OUT operations.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            out_r <= RST_OUT;
            dir_r <= RST_DIR;
            ien_r <= '0;
        end else if (access && WE_I) begin
            case (ADR_I)
                A_OUT:   out_r <= DAT_I;
                A_DIR:   dir_r <= DAT_I;
                A_SET:   out_r <= out_r | DAT_I;
                A_CLR:   out_r <= out_r & ~DAT_I;
                A_TGL:   out_r <= out_r ^ DAT_I;
                A_IEN:   ien_r <= DAT_I;
                default: ;
            endcase
        end
    end

    // Interrupt status: new edges win over a simultaneous write-one-to-clear.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            isr_r <= '0;
            int_r <= 1'b0;
        end else begin
            isr_r <= (isr_r & ~w1c) | in_rise;
            int_r <= |(isr_r & ien_r);
        end
    end

    // Read data is held only for the acknowledge cycle and is zero otherwise.
    always_ff @(posedge CLK_I) begin
        if (RST_I)                dat_r <= '0;
        else if (access && !WE_I) dat_r <= rd_data;
        else                      dat_r <= '0;
    end

    assign DAT_O = dat_r;
    assign INT_O = int_r;
    assign S_O   = out_r;
    assign S_OE  = dir_r;

endmodule
